burst_mem_responder: RTL and testbench

Memory-side responder for the 4-beat, 64-bit burst protocol that the cache line adaptor initiates toward physical memory. It accepts a read or write request with a 32-bit line address, waits a fixed latency, then asserts `resp_o` for exactly four consecutive cycles while streaming or absorbing one 64-bit beat per cycle against internal line storage. It is the synthesizable stand-in for DRAM on the memory port, used in the pipelined processor's top-level simulation and FPGA builds.

---
 rtl/burst_mem_responder.sv | 142 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory-side responder for the 4-beat, 64-bit line burst
// protocol. A request is accepted in IDLE, the fixed LATENCY is counted down,
// then resp_o is held for four cycles while one 64-bit beat per cycle is read
// from or written into line storage.
// Optional build macro: BURST_MEM_PATTERN_EN adds per-line valid bits; reads of
// lines never written since reset return an address-derived pattern.
module burst_mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  localparam int unsigned LINES    = 1 << ADDR_BITS;
  localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  state_t               state;
  op_t                  op;
  logic [ADDR_BITS-1:0] line_q;
  logic [7:0]           wait_cnt;
  logic [1:0]           beat;

  // One 64-bit word per beat; word index is {line, beat}.
  logic [63:0]          mem [LINES*4];

  logic [ADDR_BITS-1:0] line_in;
  logic                 req_active;
  logic [1:0]           rd_beat;
  logic [63:0]          rd_data;

  assign line_in = address_i[ADDR_BITS+4:5];

`ifdef BURST_MEM_PATTERN_EN
  logic [LINES-1:0] valid;
  logic [26:0]      addr_hi_q;
  logic             unused_addr_bits;
  assign unused_addr_bits = ^address_i[4:0];
`else
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{address_i[31:ADDR_BITS+5], address_i[4:0]};
`endif

  // Track whether the request that started this transaction is still held.
  always_comb begin
    req_active = (op == OP_READ) ? read_i : write_i;
  end

  // Fetch the beat that becomes visible after the next edge: beat 0 when
  // leaving WAIT, otherwise the one following the beat currently shown.
  always_comb begin
    rd_beat = (state == BURST) ? beat + 2'd1 : 2'd0;
    rd_data = mem[{line_q, rd_beat}];
`ifdef BURST_MEM_PATTERN_EN
    if (!valid[line_q]) begin
      rd_data = {addr_hi_q, rd_beat, 3'b000, ~{addr_hi_q, rd_beat, 3'b000}};
    end
`endif
  end

  // Control FSM with registered resp_o/burst_o so data stays aligned to resp_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_READ;
      line_q   <= '0;
      wait_cnt <= '0;
      beat     <= '0;
      resp_o   <= 1'b0;
      burst_o  <= '0;
`ifdef BURST_MEM_PATTERN_EN
      valid     <= '0;
      addr_hi_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            op       <= read_i ? OP_READ : OP_WRITE;
            line_q   <= line_in;
            wait_cnt <= LAT_LOAD;
            state    <= WAIT;
`ifdef BURST_MEM_PATTERN_EN
            addr_hi_q <= address_i[31:5];
`endif
          end
        end
        WAIT: begin
          if (!req_active) begin
            state <= IDLE;
          end else if (wait_cnt == 8'd0) begin
            state   <= BURST;
            beat    <= 2'd0;
            resp_o  <= 1'b1;
            burst_o <= (op == OP_READ) ? rd_data : '0;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        BURST: begin
          if (beat == 2'd3) begin
            state   <= DONE;
            resp_o  <= 1'b0;
            burst_o <= '0;
`ifdef BURST_MEM_PATTERN_EN
            if (op == OP_WRITE) begin
              valid[line_q] <= 1'b1;
            end
`endif
          end else begin
            beat    <= beat + 2'd1;
            burst_o <= (op == OP_READ) ? rd_data : '0;
          end
        end
        DONE: begin
          if (!read_i && !write_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage, deliberately not reset; a reset moves the FSM out of BURST
  // asynchronously, so no partial beat is written after it.
  always_ff @(posedge clk) begin
    if (state == BURST && op == OP_WRITE) begin
      mem[{line_q, beat}] <= burst_i;
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed testbench for burst_mem_responder (LATENCY=4, ADDR_BITS=5).
module tb_burst_mem_responder;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;

  int checks = 0;
  int errors = 0;

  burst_mem_responder #(.LATENCY(LAT), .ADDR_BITS(5)) dut (
    .clk(clk), .reset(reset), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] bin;
    logic        resp;
    logic [63:0] bo;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  function automatic void row(input logic r, input logic w, input logic [31:0] a,
                              input logic [63:0] bi, input logic er, input logic [63:0] eb);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.bin = bi; v.resp = er; v.bo = eb;
    tbl.push_back(v);
  endfunction

  // Write burst: address only valid on the accepting row, scrambled afterwards.
  function automatic void add_wr(input logic [31:0] a, input logic [3:0][63:0] d);
    logic [31:0] sc;
    sc = a ^ 32'h0000_03E0;
    row(0, 1, a, 64'hDEAD_BEEF_DEAD_BEEF, 0, '0);
    for (int i = 0; i < 3; i++) row(0, 1, sc, 64'hDEAD_BEEF_DEAD_BEEF, 0, '0);
    row(0, 1, sc, 64'hDEAD_BEEF_DEAD_BEEF, 1, '0);
    for (int k = 0; k < 3; k++) row(0, 1, sc, d[k], 1, '0);
    row(0, 1, sc, d[3], 0, '0);
    row(0, 0, '0, '0, 0, '0);
    row(0, 0, '0, '0, 0, '0);
  endfunction

  // Read burst, optionally with write_i also high and the request held in DONE.
  function automatic void add_rd(input logic [31:0] a, input logic [3:0][63:0] e,
                                 input logic w, input int hold);
    logic [31:0] sc;
    sc = a ^ 32'h0000_03E0;
    row(1, w, a | 32'h1F, 64'hBAD0_BAD0_BAD0_BAD0, 0, '0);
    for (int i = 0; i < 3; i++) row(1, w, sc, 64'hBAD0_BAD0_BAD0_BAD0, 0, '0);
    for (int k = 0; k < 4; k++) row(1, w, sc, 64'hBAD0_BAD0_BAD0_BAD0, 1, e[k]);
    for (int i = 0; i <= hold; i++) row(1, w, sc, 64'hBAD0_BAD0_BAD0_BAD0, 0, '0);
    row(0, 0, '0, '0, 0, '0);
    row(0, 0, '0, '0, 0, '0);
  endfunction

  task automatic wait_resp(input string nm);
    int n;
    n = 0;
    while (!resp_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_resp_start"}, {63'd0, resp_o}, 64'd1);
  endtask

  task automatic hs_read(input string nm, input logic [31:0] a, input logic [3:0][63:0] e);
    @(negedge clk);
    read_i = 1'b1; address_i = a;
    wait_resp(nm);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_resp%0d", nm, k), {63'd0, resp_o}, 64'd1);
      chk($sformatf("%s_beat%0d", nm, k), burst_o, e[k]);
      @(negedge clk);
    end
    chk({nm, "_resp_end"}, {63'd0, resp_o}, 64'd0);
    chk({nm, "_bo_end"}, burst_o, 64'd0);
    read_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic hs_write(input string nm, input logic [31:0] a, input logic [3:0][63:0] d,
                          input int drop_wait, input int drop_beat);
    logic seen;
    @(negedge clk);
    write_i = 1'b1; address_i = a; burst_i = '0;
    if (drop_wait != 0) begin
      @(negedge clk);
      @(negedge clk);
      write_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < int'(LAT) + 8; i++) begin
        @(negedge clk);
        if (resp_o) seen = 1'b1;
      end
      chk({nm, "_no_resp"}, {63'd0, seen}, 64'd0);
    end else begin
      wait_resp(nm);
      for (int k = 0; k < 4; k++) begin
        burst_i = d[k];
        if (k == drop_beat) write_i = 1'b0;
        chk($sformatf("%s_resp%0d", nm, k), {63'd0, resp_o}, 64'd1);
        @(negedge clk);
      end
      chk({nm, "_resp_end"}, {63'd0, resp_o}, 64'd0);
    end
    write_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0][63:0] bb, aa, cc, dd, ee, p40, p100, exp_h1, exp_h2;
    bb   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    aa   = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
            64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
    cc   = {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3,
            64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1};
    dd   = {64'hD4D4_D4D4_0000_1234, 64'hD3D3_D3D3_0000_1234,
            64'hD2D2_D2D2_0000_1234, 64'hD1D1_D1D1_0000_1234};
    ee   = {64'hE4E4_E4E4_E4E4_E4E4, 64'hE3E3_E3E3_E3E3_E3E3,
            64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1};
    p40  = {64'h0000_0058_FFFF_FFA7, 64'h0000_0050_FFFF_FFAF,
            64'h0000_0048_FFFF_FFB7, 64'h0000_0040_FFFF_FFBF};
    p100 = {64'h0000_0118_FFFF_FEE7, 64'h0000_0110_FFFF_FEEF,
            64'h0000_0108_FFFF_FEF7, 64'h0000_0100_FFFF_FEFF};
`ifdef BURST_MEM_PATTERN_EN
    exp_h1 = p40;
    exp_h2 = p40;
`else
    exp_h1 = bb;
    exp_h2 = {bb[3], bb[2], cc[1], cc[0]};
`endif

    reset = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; burst_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_resp", {63'd0, resp_o}, 64'd0);
    chk("reset_bo", burst_o, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table: write 0x40, read it back (held in DONE, then re-raised),
    // write 0x80, read 0x80 with write_i also high, read 0x80 again.
    add_wr(32'h40, bb);
    add_rd(32'h40, bb, 1'b0, 2);
    add_rd(32'h40, bb, 1'b0, 0);
    add_wr(32'h80, aa);
    add_rd(32'h80, aa, 1'b1, 0);
    add_rd(32'h80, aa, 1'b0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      read_i = tbl[i].rd; write_i = tbl[i].wr; address_i = tbl[i].addr; burst_i = tbl[i].bin;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_resp", i), {63'd0, resp_o}, {63'd0, tbl[i].resp});
      chk($sformatf("row%0d_bo", i), burst_o, tbl[i].bo);
    end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);

    // Reset while a read waits out its latency.
    read_i = 1'b1; address_i = 32'h40;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait_resp", {63'd0, resp_o}, 64'd0);
    chk("rst_wait_bo", burst_o, 64'd0);
    @(negedge clk);
    reset = 1'b0; read_i = 1'b0;
    @(negedge clk);
    hs_read("rd_after_rst", 32'h40, exp_h1);

    // Reset mid write burst: beats 0 and 1 committed, 2 and 3 untouched.
    @(negedge clk);
    write_i = 1'b1; address_i = 32'h40; burst_i = '0;
    wait_resp("wr_rst");
    burst_i = cc[0];
    @(negedge clk);
    burst_i = cc[1];
    @(negedge clk);
    burst_i = cc[2];
    #2 reset = 1'b1;
    #1;
    chk("rst_burst_resp", {63'd0, resp_o}, 64'd0);
    chk("rst_burst_bo", burst_o, 64'd0);
    @(negedge clk);
    reset = 1'b0; write_i = 1'b0;
    @(negedge clk);
    hs_read("rd_partial", 32'h40, exp_h2);

    // Write dropped in WAIT leaves the line alone; dropped in beat 1 still writes all.
    hs_write("wr_drop_wait", 32'h40, dd, 1, -1);
    hs_read("rd_drop_wait", 32'h40, exp_h2);
    hs_write("wr_drop_b1", 32'h40, dd, 0, 1);
    hs_read("rd_drop_b1", 32'h40, dd);

`ifdef BURST_MEM_PATTERN_EN
    hs_read("rd_pat100", 32'h100, p100);
    hs_write("wr_100", 32'h100, ee, 0, -1);
    hs_read("rd_100", 32'h100, ee);
`else
    hs_write("wr_100", 32'h100, ee, 0, -1);
    hs_read("rd_100", 32'h100, ee);
    hs_read("rd_80_keep", 32'h80, aa);
    p100 = '0;
    p40 = p100;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
